// File: rtl/countdown_timer64.sv
// countdown_timer64
//   Loadable down-counter with a three-state control FSM (IDLE / RUN / DONE).
//
//   Ports
//     clock    : rising-edge clock for all state
//     rst      : synchronous reset, active-high
//     load     : capture load_val and start a countdown (any state)
//     load_val : countdown start value (WIDTH bits, unsigned)
//     d_en     : decrement enable while in RUN
//     abort    : stop the countdown and return to IDLE
//     d_out    : registered current count
//     busy     : high while in RUN
//     done     : high while in DONE
//     tc       : registered one-cycle terminal-count pulse
//
//   Build option
//     COUNTDOWN_AUTO_RELOAD_EN : when defined, reaching terminal count
//       reloads the last non-zero load value and stays in RUN.
//       When undefined, terminal count goes to DONE with d_out = 0,
//       and no reload register is built.
//
//   Priority: rst > load > abort > d_en.

module countdown_timer64 #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             d_en,
    input  logic             abort,
    output logic [WIDTH-1:0] d_out,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q,    tc_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            tc_q     <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            tc_q     <= tc_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    // Next-state and next-count logic
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        tc_d     = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        if (load) begin
            if (load_val != '0) begin
                state_d  = RUN;
                count_d  = load_val;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                reload_d = load_val;
`endif
            end else begin
                // Zero load terminates immediately with a terminal-count pulse.
                state_d = DONE;
                count_d = '0;
                tc_d    = 1'b1;
            end
        end else if (abort) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (d_en) begin
                        if (count_q > WIDTH'(1)) begin
                            count_d = count_q - WIDTH'(1);
                        end else if (count_q == WIDTH'(1)) begin
                            tc_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            count_d = reload_q;
`else
                            count_d = '0;
                            state_d = DONE;
`endif
                        end
                        // count_q == 0 in RUN: hold, never wrap.
                    end
                end
                DONE: begin
                    count_d = '0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output decode
    always_comb begin
        busy  = (state_q == RUN);
        done  = (state_q == DONE);
        d_out = count_q;
        tc    = tc_q;
    end

endmodule

// File: tb/tb_countdown_timer64.sv
// Scoreboard bench for countdown_timer64 (WIDTH = 64).
// The stimulus process drives one input vector per cycle and queues the
// hand-computed output expected after the following rising edge, tagged
// with that edge's cycle number. The monitor compares on the falling edge.

module tb_countdown_timer64;

    localparam int unsigned W = 64;

    logic         clock;
    logic         rst;
    logic         load;
    logic [W-1:0] load_val;
    logic         d_en;
    logic         abort;
    logic [W-1:0] d_out;
    logic         busy;
    logic         done;
    logic         tc;

    countdown_timer64 #(.WIDTH(W)) dut (
        .clock    (clock),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .d_en     (d_en),
        .abort    (abort),
        .d_out    (d_out),
        .busy     (busy),
        .done     (done),
        .tc       (tc)
    );

    typedef struct {
        int unsigned  cyc;
        logic [W-1:0] d;
        logic         b;
        logic         dn;
        logic         t;
        string        name;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int unsigned cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: pop every entry due at this cycle and compare.
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc || d_out !== e.d || busy !== e.b ||
                done !== e.dn || tc !== e.t) begin
                errors++;
                $display("FAIL %s: got d_out=%0h busy=%0b done=%0b tc=%0b, expected d_out=%0h busy=%0b done=%0b tc=%0b",
                         e.name, d_out, busy, done, tc, e.d, e.b, e.dn, e.t);
            end
        end
    end

    // Drive one cycle of inputs and queue the output expected after the next edge.
    task automatic step(input logic r, input logic ld, input logic [W-1:0] lv,
                        input logic de, input logic ab,
                        input logic [W-1:0] ed, input logic eb, input logic edn,
                        input logic et, input string nm);
        exp_t x;
        @(posedge clock);
        #1;
        rst      = r;
        load     = ld;
        load_val = lv;
        d_en     = de;
        abort    = ab;
        x.cyc  = cyc + 1;
        x.d    = ed;
        x.b    = eb;
        x.dn   = edn;
        x.t    = et;
        x.name = nm;
        sb.push_back(x);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; load_val = '0; d_en = 1'b0; abort = 1'b0;

        //    rst ld  load_val               de  ab    d_out                  b  dn t
        step(1, 0, 64'd0,                   0, 0,   64'd0,                 0, 0, 0, "reset");
        step(1, 1, 64'd9,                   1, 1,   64'd0,                 0, 0, 0, "reset_over_load");

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        step(0, 1, 64'd2,                   1, 0,   64'd2,                 1, 0, 0, "ar_load2");
        step(0, 0, 64'd0,                   1, 0,   64'd1,                 1, 0, 0, "ar_dec1");
        step(0, 0, 64'd0,                   1, 0,   64'd2,                 1, 0, 1, "ar_reload_tc");
        step(0, 0, 64'd0,                   1, 0,   64'd1,                 1, 0, 0, "ar_dec1_b");
        step(0, 0, 64'd0,                   1, 0,   64'd2,                 1, 0, 1, "ar_reload_tc_b");
        step(0, 0, 64'd0,                   0, 0,   64'd2,                 1, 0, 0, "ar_hold");
`else
        step(0, 1, 64'd3,                   1, 0,   64'd3,                 1, 0, 0, "cd_load3");
        step(0, 0, 64'd0,                   1, 0,   64'd2,                 1, 0, 0, "cd_dec2");
        step(0, 0, 64'd0,                   1, 0,   64'd1,                 1, 0, 0, "cd_dec1");
        step(0, 0, 64'd0,                   1, 0,   64'd0,                 0, 1, 1, "cd_terminal_tc");
        step(0, 0, 64'd0,                   1, 0,   64'd0,                 0, 1, 0, "cd_done_hold");
        step(0, 0, 64'd0,                   1, 0,   64'd0,                 0, 1, 0, "cd_done_no_wrap");
`endif

        // d_en toggling: 5,4,4,3,3
        step(0, 1, 64'd5,                   1, 0,   64'd5,                 1, 0, 0, "tog_load5");
        step(0, 0, 64'd0,                   1, 0,   64'd4,                 1, 0, 0, "tog_dec4");
        step(0, 0, 64'd0,                   0, 0,   64'd4,                 1, 0, 0, "tog_hold4");
        step(0, 0, 64'd0,                   1, 0,   64'd3,                 1, 0, 0, "tog_dec3");
        step(0, 0, 64'd0,                   0, 0,   64'd3,                 1, 0, 0, "tog_hold3");

        // abort from RUN, then abort / d_en in IDLE do nothing
        step(0, 0, 64'd0,                   1, 1,   64'd0,                 0, 0, 0, "abort_run");
        step(0, 0, 64'd0,                   0, 1,   64'd0,                 0, 0, 0, "abort_idle");
        step(0, 0, 64'd0,                   1, 0,   64'd0,                 0, 0, 0, "den_idle");

        // zero load
        step(0, 1, 64'd0,                   1, 0,   64'd0,                 0, 1, 1, "zero_load_tc");
        step(0, 0, 64'd0,                   0, 0,   64'd0,                 0, 1, 0, "zero_load_done");
        step(0, 0, 64'd0,                   1, 0,   64'd0,                 0, 1, 0, "zero_load_den");

        // load beats abort and d_en
        step(0, 1, 64'd10,                  0, 0,   64'd10,                1, 0, 0, "load10");
        step(0, 1, 64'd7,                   1, 1,   64'd7,                 1, 0, 0, "load_over_abort");
        step(0, 0, 64'd0,                   0, 1,   64'd0,                 0, 0, 0, "abort_alone");

        // reset coincident with terminal count
        step(0, 1, 64'd2,                   1, 0,   64'd2,                 1, 0, 0, "rtc_load2");
        step(0, 0, 64'd0,                   1, 0,   64'd1,                 1, 0, 0, "rtc_dec1");
        step(1, 0, 64'd0,                   1, 0,   64'd0,                 0, 0, 0, "rst_at_tc");

        // full-width unsigned values
        step(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0,   64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, "max_load");
        step(0, 0, 64'd0,                   1, 0,   64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, "max_dec");
        step(0, 1, 64'h8000_0000_0000_0000, 1, 0,   64'h8000_0000_0000_0000, 1, 0, 0, "msb_load");
        step(0, 0, 64'd0,                   1, 0,   64'h7FFF_FFFF_FFFF_FFFF, 1, 0, 0, "msb_dec");
        step(1, 0, 64'd0,                   0, 0,   64'd0,                 0, 0, 0, "final_reset");

        step(0, 0, 64'd0,                   0, 0,   64'd0,                 0, 0, 0, "idle_after_reset");

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
        #1;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
